spatial_sram_responder: RTL and testbench
=========================================

# spatial_sram_responder

Memory-side responder for one modality of the spatial encoder. It holds the item-memory (iM), negative projection (projM_neg) and positive projection (projM_pos) hypervector banks, and answers the encoder's per-channel address requests with the three rows plus per-bank ready/valid. A sequential-address prefetch sustains one channel per cycle. The design instantiates it once per modality, between the host load path and the spatial encoder's SRAM ports.

## Interface
- `HV_DIMENSION`, default `HV_DIMENSION` (2000): hypervector width in bits.
- `DEPTH`, default `INPUT_CHANNELS` (214): rows per bank.
- `ADDR_W`, default `ceilLog2(DEPTH)`: address width.

Ports:
- `Clk_CI`  in  1  the single clock.
- `Reset_RBI`  in  1  reset, **asynchronous, active-low**.
- `LoadValid_SI`  in  1  load beat valid.
- `LoadReady_SO`  out  1  responder accepts load beats (LOAD state only).
- `LoadBank_DI`  in  2  target bank: 0 = iM, 1 = projM_neg, 2 = projM_pos; 3 = ignored.
- `LoadAddr_DI`  in  ADDR_W  row to write.
- `LoadData_DI`  in  HV_DIMENSION  row data.
- `LoadDone_SI`  in  1  ends the load phase.
- `ReqValid_SI`  in  1  encoder spatial_valid.
- `ReqReady_SI`  in  1  encoder spatial_ready; consumption qualifier.
- `ReqAddr_DI`  in  ADDR_W  encoder sram_addr.
- `BankReady_SO`  out  3  per-bank ready {iM, neg, pos}.
- `BankValid_SO`  out  3  per-bank valid {iM, neg, pos}.
- `IMOut_DO`  out  HV_DIMENSION  iM row.
- `ProjMNeg_DO`  out  HV_DIMENSION  projM_neg row.
- `ProjMPos_DO`  out  HV_DIMENSION  projM_pos row.
- `AddrErr_SO`  out  1  sticky: a request used an address ≥ DEPTH.

## Operation
- **States:** LOAD (reset state) and SERVE.
- **LOAD**
  - `LoadReady_SO` = 1.
  - A beat with `LoadValid_SI` writes `LoadData_DI` to bank `LoadBank_DI` at row `LoadAddr_DI`.
  - A beat is ignored if the bank is 3 or the address is ≥ DEPTH.
  - `LoadDone_SI` moves the block to SERVE on the next edge. A beat in that same cycle is still written.
  - Request inputs are ignored and `BankValid_SO` = 0.
- **SERVE**
  - `LoadReady_SO` = 0 and `BankReady_SO` = 3'b111.
  - There is no return to LOAD except through reset.
- **Registers:** tag `Tag_Q` (ADDR_W bits) and flag `DataValid_Q`.
- **Hit** = `DataValid_Q` && `ReqValid_SI` && (`Tag_Q` == `ReqAddr_DI`).
  - `BankValid_SO` = {3{Hit}}.
  - The valid path from `ReqAddr_DI` to `BankValid_SO` is combinational, so valid drops in the same cycle the encoder's address changes.
- **Read address R issued each SERVE cycle:**
  - Consume (Hit && `ReqReady_SI`): R = `ReqAddr_DI` + 1, wrapping DEPTH-1 → 0.
  - Otherwise: R = `ReqAddr_DI`.
- **Next edge:** `Tag_Q` ← R and `DataValid_Q` ← `ReqValid_SI` && (R < DEPTH). The banks return row R on the outputs.
- **Out-of-range address:** if `ReqValid_SI` is high and `ReqAddr_DI` ≥ DEPTH, `AddrErr_SO` sets and stays set until reset. `BankValid_SO` stays 0 for that address.
- **Output data:** holds the last read row. It is undefined before the first SERVE read.

## Timing
- **Reset values (during and after reset):**
  - state = LOAD, `DataValid_Q` = 0, `Tag_Q` = 0.
  - `BankValid_SO` = 0, `BankReady_SO` = 0, `AddrErr_SO` = 0, `LoadReady_SO` = 1.
  - Read data registers clear to 0. Bank contents are not reset.
- **Bank read latency:** 1 cycle. A write is visible to a read issued on the following cycle.
- **First request after idle or miss:** valid asserts 1 cycle after `ReqValid_SI` rises with a stable address.
- **Sequential streaming:** after the first hit, one hit per cycle while the encoder consumes in order, including the wrap DEPTH-1 → 0.
- **Non-sequential jump:** costs exactly 1 miss cycle.
- **Stall:** `ReqReady_SI` = 0 with an unchanged address keeps Hit high and the data stable.
- **Reset mid-stream:** async reset drops `BankValid_SO` immediately. The banks must be reloaded only if the host chooses; a reset returns the block to LOAD regardless.

## Structure
- **Shared package / const.vh:** `HV_DIMENSION`, `INPUT_CHANNELS`, the per-modality channel counts, `ceilLog2`, and the bank-index constants `BANK_IM`, `BANK_NEG`, `BANK_POS`.
- **Sub-module `hv_sram_bank`:** DEPTH×HV_DIMENSION array with one write port, one synchronous read port and a registered output. It is instantiated three times. The responder holds only the FSM, the tag/prefetch logic and the error flag.

## Test plan
- Load iM rows 0..3 as 0xA5 patterns, then `LoadDone_SI`, then request address 0:
  - `BankValid_SO` = 111 one cycle later.
  - `IMOut_DO` = row 0.
- Consume addresses 0→1→2→3 each cycle:
  - `BankValid_SO` stays 111 on 4 consecutive cycles.
  - Data matches rows 0..3 in order.
- Hit at 5 with `ReqReady_SI` = 0 for 3 cycles:
  - valid stays high and data stays row 5.
  - Release: row 6 is valid the next cycle.
- Stream to DEPTH-1 = 213 and consume:
  - at address 0 next cycle, valid = 111 with row 0 (wrap prefetch).
- Jump 7 → 40:
  - one cycle with valid = 0, then row 40 valid.
- Request address 250:
  - `AddrErr_SO` rises and stays 1, valid stays 0.
- Assert `Reset_RBI` = 0 mid-stream:
  - outputs return to reset values asynchronously.
  - state is LOAD and `LoadReady_SO` = 1.

Source files
------------

// File: rtl/spatial_sram_responder_pkg.sv
// ============================================================================
// Module  : spatial_sram_responder_pkg
// Purpose : Shared constants, bank-index codes, the responder state type and
//           the ceilLog2 helper used by the spatial SRAM responder.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package spatial_sram_responder_pkg;

   localparam int HV_DIMENSION   = 2000;
   localparam int INPUT_CHANNELS = 214;

   // Per-modality channel counts; together they fill INPUT_CHANNELS.
   localparam int GSR_CHANNELS = 32;
   localparam int ECG_CHANNELS = 77;
   localparam int EEG_CHANNELS = 105;

   // Bank selector codes on the load path; code 3 is a discarded beat.
   localparam logic [1:0] BANK_IM  = 2'd0;
   localparam logic [1:0] BANK_NEG = 2'd1;
   localparam logic [1:0] BANK_POS = 2'd2;

   typedef enum logic {
      ST_LOAD  = 1'b0,
      ST_SERVE = 1'b1
   } resp_state_t;

   // Number of bits needed to address 'value' distinct locations (min 1).
   function automatic int ceilLog2(input int value);
      int bits;
      bits = 1;
      while ((1 << bits) < value) begin
         bits = bits + 1;
      end
      return bits;
   endfunction

endpackage

`default_nettype wire

// File: rtl/spatial_sram_responder_hv_sram_bank.sv
// ============================================================================
// Module  : hv_sram_bank
// Purpose : DEPTH x HV_DIMENSION hypervector storage with one write port and
//           one synchronous read port feeding a registered output.
// Ports   : clk      - clock
//           rst_n    - asynchronous active-low reset (clears read register)
//           wr_en    - write strobe, wr_addr / wr_data - write row and data
//           rd_en    - read strobe, rd_addr - read row
//           rd_data  - registered read data, holds the last read row
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hv_sram_bank #(
   parameter int HV_DIMENSION = 2000,
   parameter int DEPTH        = 214,
   parameter int ADDR_W       = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    wr_en,
   input  logic [ADDR_W-1:0]       wr_addr,
   input  logic [HV_DIMENSION-1:0] wr_data,
   input  logic                    rd_en,
   input  logic [ADDR_W-1:0]       rd_addr,
   output logic [HV_DIMENSION-1:0] rd_data
);

   // Storage is deliberately not reset so it maps onto a plain SRAM macro.
   logic [HV_DIMENSION-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

`default_nettype wire

// File: rtl/spatial_sram_responder.sv
// ============================================================================
// Module  : spatial_sram_responder
// Purpose : Memory-side responder for one spatial-encoder modality. Holds the
//           iM, projM_neg and projM_pos banks, is loaded by the host during
//           LOAD, then answers encoder address requests in SERVE with a
//           one-entry tag and sequential prefetch so in-order streaming
//           sustains one hit per cycle.
// Ports   : Clk_CI / Reset_RBI          - clock, async active-low reset
//           LoadValid_SI / LoadReady_SO - load beat handshake
//           LoadBank_DI / LoadAddr_DI / LoadData_DI - load beat payload
//           LoadDone_SI                 - end of load phase
//           ReqValid_SI / ReqReady_SI / ReqAddr_DI - encoder request
//           BankReady_SO / BankValid_SO - per-bank {iM, neg, pos} flags
//           IMOut_DO / ProjMNeg_DO / ProjMPos_DO - bank read data
//           AddrErr_SO                  - sticky out-of-range request flag
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module spatial_sram_responder #(
   parameter int HV_DIMENSION = spatial_sram_responder_pkg::HV_DIMENSION,
   parameter int DEPTH        = spatial_sram_responder_pkg::INPUT_CHANNELS,
   parameter int ADDR_W       = spatial_sram_responder_pkg::ceilLog2(DEPTH)
) (
   input  logic                    Clk_CI,
   input  logic                    Reset_RBI,
   input  logic                    LoadValid_SI,
   output logic                    LoadReady_SO,
   input  logic [1:0]              LoadBank_DI,
   input  logic [ADDR_W-1:0]       LoadAddr_DI,
   input  logic [HV_DIMENSION-1:0] LoadData_DI,
   input  logic                    LoadDone_SI,
   input  logic                    ReqValid_SI,
   input  logic                    ReqReady_SI,
   input  logic [ADDR_W-1:0]       ReqAddr_DI,
   output logic [2:0]              BankReady_SO,
   output logic [2:0]              BankValid_SO,
   output logic [HV_DIMENSION-1:0] IMOut_DO,
   output logic [HV_DIMENSION-1:0] ProjMNeg_DO,
   output logic [HV_DIMENSION-1:0] ProjMPos_DO,
   output logic                    AddrErr_SO
);

   import spatial_sram_responder_pkg::*;

   // One extra bit so DEPTH itself is representable when DEPTH == 2**ADDR_W.
   localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   resp_state_t       state;
   logic [ADDR_W-1:0] tag_q;
   logic              data_valid_q;
   logic              load_ready_q;
   logic [2:0]        bank_ready_q;
   logic              addr_err_q;

   logic              hit;
   logic              consume;
   logic              req_in_range;
   logic              load_in_range;
   logic              load_write;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_in_range;
   logic              rd_en;

   logic [HV_DIMENSION-1:0] bank_rd_data [3];

   // The tag only ever holds an in-range row while data_valid_q is set, and
   // data_valid_q is only set in SERVE, so no state qualifier is needed here.
   assign hit     = data_valid_q && ReqValid_SI && (tag_q == ReqAddr_DI);
   assign consume = hit && ReqReady_SI;

   assign req_in_range  = {1'b0, ReqAddr_DI}  < DEPTH_EXT;
   assign load_in_range = {1'b0, LoadAddr_DI} < DEPTH_EXT;

   // On a consume the encoder moves to the next row, so fetch it now; this is
   // what keeps in-order streaming at one hit per cycle, including the wrap.
   always_comb begin
      rd_addr = ReqAddr_DI;
      if (consume) begin
         rd_addr = (ReqAddr_DI == LAST_ADDR) ? '0 : ReqAddr_DI + 1'b1;
      end
   end

   assign rd_in_range = {1'b0, rd_addr} < DEPTH_EXT;
   assign rd_en       = (state == ST_SERVE) && rd_in_range;
   assign load_write  = (state == ST_LOAD) && LoadValid_SI && load_in_range;

   always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
      if (!Reset_RBI) begin
         state        <= ST_LOAD;
         tag_q        <= '0;
         data_valid_q <= 1'b0;
         load_ready_q <= 1'b1;
         bank_ready_q <= 3'b000;
         addr_err_q   <= 1'b0;
      end else begin
         case (state)
            ST_LOAD: begin
               if (LoadDone_SI) begin
                  state        <= ST_SERVE;
                  load_ready_q <= 1'b0;
                  bank_ready_q <= 3'b111;
               end
            end
            ST_SERVE: begin
               tag_q        <= rd_addr;
               data_valid_q <= ReqValid_SI && rd_in_range;
               if (ReqValid_SI && !req_in_range) begin
                  addr_err_q <= 1'b1;
               end
            end
            default: begin
               state <= ST_LOAD;
            end
         endcase
      end
   end

   // Bank i is selected by load code i (BANK_IM, BANK_NEG, BANK_POS).
   for (genvar i = 0; i < 3; i++) begin : g_bank
      hv_sram_bank #(
         .HV_DIMENSION (HV_DIMENSION),
         .DEPTH        (DEPTH),
         .ADDR_W       (ADDR_W)
      ) u_bank (
         .clk     (Clk_CI),
         .rst_n   (Reset_RBI),
         .wr_en   (load_write && (LoadBank_DI == 2'(i))),
         .wr_addr (LoadAddr_DI),
         .wr_data (LoadData_DI),
         .rd_en   (rd_en),
         .rd_addr (rd_addr),
         .rd_data (bank_rd_data[i])
      );
   end

   assign LoadReady_SO = load_ready_q;
   assign BankReady_SO = bank_ready_q;
   assign BankValid_SO = {3{hit}};
   assign AddrErr_SO   = addr_err_q;
   assign IMOut_DO     = bank_rd_data[BANK_IM];
   assign ProjMNeg_DO  = bank_rd_data[BANK_NEG];
   assign ProjMPos_DO  = bank_rd_data[BANK_POS];

endmodule

`default_nettype wire

// File: tb/tb_spatial_sram_responder.sv
// ============================================================================
// Module  : tb_spatial_sram_responder
// Purpose : Self-checking bench for spatial_sram_responder. Loads all three
//           banks with distinct patterns, then drives encoder request
//           sequences whose expected per-cycle results are queued when each
//           request is driven and compared when the cycle is sampled.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spatial_sram_responder;

   import spatial_sram_responder_pkg::*;

   localparam int HV    = 128;
   localparam int DEPTH = INPUT_CHANNELS;
   localparam int AW    = ceilLog2(DEPTH);

   logic          clk;
   logic          rst_n;
   logic          load_valid;
   logic          load_ready;
   logic [1:0]    load_bank;
   logic [AW-1:0] load_addr;
   logic [HV-1:0] load_data;
   logic          load_done;
   logic          req_valid;
   logic          req_ready;
   logic [AW-1:0] req_addr;
   logic [2:0]    bank_ready;
   logic [2:0]    bank_valid;
   logic [HV-1:0] im_out;
   logic [HV-1:0] neg_out;
   logic [HV-1:0] pos_out;
   logic          addr_err;

   spatial_sram_responder #(
      .HV_DIMENSION (HV),
      .DEPTH        (DEPTH),
      .ADDR_W       (AW)
   ) dut (
      .Clk_CI       (clk),
      .Reset_RBI    (rst_n),
      .LoadValid_SI (load_valid),
      .LoadReady_SO (load_ready),
      .LoadBank_DI  (load_bank),
      .LoadAddr_DI  (load_addr),
      .LoadData_DI  (load_data),
      .LoadDone_SI  (load_done),
      .ReqValid_SI  (req_valid),
      .ReqReady_SI  (req_ready),
      .ReqAddr_DI   (req_addr),
      .BankReady_SO (bank_ready),
      .BankValid_SO (bank_valid),
      .IMOut_DO     (im_out),
      .ProjMNeg_DO  (neg_out),
      .ProjMPos_DO  (pos_out),
      .AddrErr_SO   (addr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]      valid;
      bit              chk_data;
      logic [3*HV-1:0] data;
      logic            err;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // 0xA5 background with a bank/row signature in the low word.
   function automatic logic [HV-1:0] pat(input int b, input int a);
      logic [HV-1:0] p;
      p = {(HV/8){8'hA5}};
      p[31:0] = p[31:0] ^ {8'(b + 1), 8'(a), ~8'(a), 8'(b * 37)};
      return p;
   endfunction

   // Drives one request cycle and queues what the responder should show.
   task automatic drive(input int addr, input bit [3:0] f);
      exp_t e;
      req_addr   = AW'(addr);
      req_valid  = f[3];
      req_ready  = f[2];
      e.valid    = f[1] ? 3'b111 : 3'b000;
      e.chk_data = f[1];
      e.data     = {pat(0, addr), pat(1, addr), pat(2, addr)};
      e.err      = f[0];
      sb.push_back(e);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req_valid = 1'b1;
      req_addr  = '0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (load_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_load_ready: got %b exp 1", load_ready);
      end
      n_checks++;
      if (bank_ready !== 3'b000 || bank_valid !== 3'b000) begin
         n_fail++; $display("FAIL reset_bank_flags: got ready %b valid %b exp 000/000", bank_ready, bank_valid);
      end
      n_checks++;
      if (addr_err !== 1'b0) begin
         n_fail++; $display("FAIL reset_addr_err: got %b exp 0", addr_err);
      end
      n_checks++;
      if ({im_out, neg_out, pos_out} !== '0) begin
         n_fail++; $display("FAIL reset_data: got %h exp 0", {im_out, neg_out, pos_out});
      end
      rst_n = 1'b1;
      req_valid = 1'b0;
   endtask

   task automatic test_load();
      int total;
      total = 3 * DEPTH;
      for (int k = 0; k < total + 2; k++) begin
         load_valid = 1'b1;
         load_done  = 1'b0;
         if (k < total - 1) begin
            load_bank = 2'(k / DEPTH);
            load_addr = AW'(k % DEPTH);
            load_data = pat(k / DEPTH, k % DEPTH);
         end else if (k == total - 1) begin
            // Bank code 3 must be discarded: would corrupt row 0 otherwise.
            load_bank = 2'd3; load_addr = '0; load_data = '1;
         end else if (k == total) begin
            // Out-of-range row must be discarded.
            load_bank = BANK_IM; load_addr = AW'(250); load_data = '1;
         end else begin
            // Final real beat shares its cycle with LoadDone.
            load_bank = BANK_POS; load_addr = AW'(DEPTH - 1);
            load_data = pat(2, DEPTH - 1); load_done = 1'b1;
         end
         // Requests during LOAD must be ignored, including bad addresses.
         req_valid = 1'b1;
         req_ready = 1'b1;
         req_addr  = (k % 2 == 0) ? AW'(250) : AW'(k % DEPTH);
         @(negedge clk);
         n_checks++;
         if (load_ready !== 1'b1 || bank_valid !== 3'b000 || addr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL load_phase beat %0d: got ready %b valid %b err %b exp 1/000/0", k, load_ready, bank_valid, addr_err);
         end
         @(posedge clk); #1;
      end
      load_valid = 1'b0; load_done = 1'b0; req_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (load_ready !== 1'b0 || bank_ready !== 3'b111 || bank_valid !== 3'b000 || addr_err !== 1'b0) begin
         n_fail++;
         $display("FAIL enter_serve: got ready %b bank_ready %b valid %b err %b exp 0/111/000/0", load_ready, bank_ready, bank_valid, addr_err);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_sequential();
      int       a[$];
      bit [3:0] f[$];
      exp_t     e;
      a = '{0, 0, 1, 2, 3};
      f = '{4'b1100, 4'b1110, 4'b1110, 4'b1110, 4'b1110};
      for (int i = 0; i < a.size(); i++) begin
         drive(a[i], f[i]);
         @(negedge clk);
         e = sb.pop_front();
         n_checks++;
         if (bank_valid !== e.valid || addr_err !== e.err) begin
            n_fail++; $display("FAIL seq_valid step %0d: got %b/%b exp %b/%b", i, bank_valid, addr_err, e.valid, e.err);
         end
         if (e.chk_data) begin
            n_checks++;
            if ({im_out, neg_out, pos_out} !== e.data) begin
               n_fail++; $display("FAIL seq_data step %0d: got %h exp %h", i, {im_out, neg_out, pos_out}, e.data);
            end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_stall();
      int       a[$];
      bit [3:0] f[$];
      exp_t     e;
      a = '{4, 5, 5, 5, 5, 6};
      f = '{4'b1110, 4'b1010, 4'b1010, 4'b1010, 4'b1110, 4'b1110};
      for (int i = 0; i < a.size(); i++) begin
         drive(a[i], f[i]);
         @(negedge clk);
         e = sb.pop_front();
         n_checks++;
         if (bank_valid !== e.valid || addr_err !== e.err) begin
            n_fail++; $display("FAIL stall_valid step %0d: got %b/%b exp %b/%b", i, bank_valid, addr_err, e.valid, e.err);
         end
         if (e.chk_data) begin
            n_checks++;
            if ({im_out, neg_out, pos_out} !== e.data) begin
               n_fail++; $display("FAIL stall_data step %0d: got %h exp %h", i, {im_out, neg_out, pos_out}, e.data);
            end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_wrap();
      int       a[$];
      bit [3:0] f[$];
      exp_t     e;
      a = '{210, 210, 211, 212, 213, 0, 1};
      f = '{4'b1100, 4'b1110, 4'b1110, 4'b1110, 4'b1110, 4'b1110, 4'b1110};
      for (int i = 0; i < a.size(); i++) begin
         drive(a[i], f[i]);
         @(negedge clk);
         e = sb.pop_front();
         n_checks++;
         if (bank_valid !== e.valid || addr_err !== e.err) begin
            n_fail++; $display("FAIL wrap_valid step %0d: got %b/%b exp %b/%b", i, bank_valid, addr_err, e.valid, e.err);
         end
         if (e.chk_data) begin
            n_checks++;
            if ({im_out, neg_out, pos_out} !== e.data) begin
               n_fail++; $display("FAIL wrap_data step %0d: got %h exp %h", i, {im_out, neg_out, pos_out}, e.data);
            end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_jump();
      int       a[$];
      bit [3:0] f[$];
      exp_t     e;
      // 7 -> 40 jump, then a cycle with ReqValid low invalidates the tag.
      a = '{7, 7, 40, 40, 41, 41, 41};
      f = '{4'b1100, 4'b1110, 4'b1100, 4'b1110, 4'b0100, 4'b1000, 4'b1010};
      for (int i = 0; i < a.size(); i++) begin
         drive(a[i], f[i]);
         @(negedge clk);
         e = sb.pop_front();
         n_checks++;
         if (bank_valid !== e.valid || addr_err !== e.err) begin
            n_fail++; $display("FAIL jump_valid step %0d: got %b/%b exp %b/%b", i, bank_valid, addr_err, e.valid, e.err);
         end
         if (e.chk_data) begin
            n_checks++;
            if ({im_out, neg_out, pos_out} !== e.data) begin
               n_fail++; $display("FAIL jump_data step %0d: got %h exp %h", i, {im_out, neg_out, pos_out}, e.data);
            end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_addr_err();
      int       a[$];
      bit [3:0] f[$];
      exp_t     e;
      a = '{250, 250, 42, 42, 43};
      f = '{4'b1100, 4'b1101, 4'b1101, 4'b1111, 4'b1111};
      for (int i = 0; i < a.size(); i++) begin
         drive(a[i], f[i]);
         @(negedge clk);
         e = sb.pop_front();
         n_checks++;
         if (bank_valid !== e.valid || addr_err !== e.err) begin
            n_fail++; $display("FAIL err_valid step %0d: got %b/%b exp %b/%b", i, bank_valid, addr_err, e.valid, e.err);
         end
         if (e.chk_data) begin
            n_checks++;
            if ({im_out, neg_out, pos_out} !== e.data) begin
               n_fail++; $display("FAIL err_data step %0d: got %h exp %h", i, {im_out, neg_out, pos_out}, e.data);
            end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_midstream();
      exp_t e;
      drive(44, 4'b1111);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (bank_valid !== e.valid || addr_err !== e.err) begin
         n_fail++; $display("FAIL midrst_pre: got %b/%b exp %b/%b", bank_valid, addr_err, e.valid, e.err);
      end
      // Assert reset between clock edges; outputs must react without a clock.
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (bank_valid !== 3'b000 || bank_ready !== 3'b000 || addr_err !== 1'b0 || load_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_flags: got valid %b ready %b err %b load_ready %b exp 000/000/0/1", bank_valid, bank_ready, addr_err, load_ready);
      end
      n_checks++;
      if ({im_out, neg_out, pos_out} !== '0) begin
         n_fail++; $display("FAIL midrst_data: got %h exp 0", {im_out, neg_out, pos_out});
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      // Back in LOAD: the same request must be ignored on later edges.
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (bank_valid !== 3'b000 || load_ready !== 1'b1 || bank_ready !== 3'b000) begin
         n_fail++; $display("FAIL midrst_load: got valid %b load_ready %b bank_ready %b exp 000/1/000", bank_valid, load_ready, bank_ready);
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      load_valid = 1'b0;
      load_bank  = '0;
      load_addr  = '0;
      load_data  = '0;
      load_done  = 1'b0;
      req_valid  = 1'b0;
      req_ready  = 1'b0;
      req_addr   = '0;

      test_reset();
      test_load();
      test_sequential();
      test_stall();
      test_wrap();
      test_jump();
      test_addr_err();
      test_reset_midstream();

      n_checks++;
      if (sb.size() !== 0) begin
         n_fail++; $display("FAIL scoreboard_drain: got %0d entries exp 0", sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
